time_set_ctrl: RTL



---
 rtl/time_set_ctrl.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/time_set_ctrl.sv
// time_set_ctrl
//   Front-end control for the six-digit HH:MM:SS clock. Synchronizes and
//   debounces the MODE and ADJUST keys, steps a RUN / SET_HOUR / SET_MIN mode
//   machine, and issues single-cycle strobes for the hour/minute/seconds
//   counters plus per-digit blanking used to blink the field being set.
//
// Ports
//   iClk        system clock
//   iRst        synchronous, active-high reset
//   iKeyMode    raw MODE key, asynchronous, active-low
//   iKeyAdj     raw ADJUST key, asynchronous, active-low
//   oRunEn      seconds counter may advance (RUN only)
//   oIncHour    one-cycle hour increment strobe
//   oIncMin     one-cycle minute increment strobe
//   oClrSec     one-cycle seconds clear strobe (on return to RUN)
//   oMode       0 = RUN, 1 = SET_HOUR, 2 = SET_MIN
//   oBlankMask  bit i = 1 blanks HEXi
module time_set_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_RATE     = 5_000_000,
  parameter int BLINK_HALF      = 12_500_000
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iKeyMode,
  input  logic       iKeyAdj,
  output logic       oRunEn,
  output logic       oIncHour,
  output logic       oIncMin,
  output logic       oClrSec,
  output logic [1:0] oMode,
  output logic [5:0] oBlankMask
);

  localparam int DB_W  = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int REP_W = ($clog2(REP_MAX) < 1) ? 1 : $clog2(REP_MAX);
  localparam int BL_W  = ($clog2(BLINK_HALF) < 1) ? 1 : $clog2(BLINK_HALF);

  localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [REP_W-1:0] RD_MAX  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] RR_MAX  = REP_W'(REPEAT_RATE - 1);
  localparam logic [BL_W-1:0]  BL_MAX  = BL_W'(BLINK_HALF - 1);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HOUR = 2'd1,
    ST_MIN  = 2'd2
  } state_e;

  // Key index: bit 0 = MODE, bit 1 = ADJUST. Key levels are active-low.
  logic [1:0]            sync1_q, sync1_d;
  logic [1:0]            sync2_q, sync2_d;
  logic [1:0]            db_q, db_d;
  logic [1:0]            db_prev_q, db_prev_d;
  logic [1:0]            press_q, press_d;
  logic [1:0][DB_W-1:0]  dcnt_q, dcnt_d;
  logic                  hold_q, hold_d;

  state_e                state_q, state_d;
  logic                  armed_q, armed_d;
  logic                  first_q, first_d;
  logic [REP_W-1:0]      rcnt_q, rcnt_d;
  logic [BL_W-1:0]       bcnt_q, bcnt_d;
  logic                  phase_q, phase_d;

  logic                  run_en_q, run_en_d;
  logic                  inc_hour_q, inc_hour_d;
  logic                  inc_min_q, inc_min_d;
  logic                  clr_sec_q, clr_sec_d;
  logic [5:0]            mask_q, mask_d;

  logic                  strobe;
  logic                  blink_clr;
  logic [REP_W-1:0]      rep_lim;

  // Key front end: synchronizer, debounce, press-edge detect
  always_comb begin
    sync1_d   = {iKeyAdj, iKeyMode};
    sync2_d   = sync1_q;
    db_prev_d = db_q;
    db_d      = db_q;
    dcnt_d    = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != db_q[i]) begin
        if (dcnt_q[i] == DB_MAX) begin
          db_d[i] = sync2_q[i];
        end else begin
          dcnt_d[i] = dcnt_q[i] + 1'b1;
        end
      end
    end
    // Falling debounced level = press; released->pressed only.
    press_d = db_prev_q & ~db_q;
    // Held flag delayed to line up with the press pipeline, so the repeat
    // engine sees the release at the same depth it saw the press.
    hold_d  = ~db_prev_q[1];
  end

  // Mode machine, auto-repeat and blink
  always_comb begin
    state_d    = state_q;
    armed_d    = armed_q;
    first_d    = first_q;
    rcnt_d     = rcnt_q;
    bcnt_d     = bcnt_q;
    phase_d    = phase_q;
    strobe     = 1'b0;
    blink_clr  = 1'b0;
    clr_sec_d  = 1'b0;
    rep_lim    = first_q ? RD_MAX : RR_MAX;

    if (press_q[0]) begin
      // MODE wins over a coincident ADJ press; any repeat is dropped.
      armed_d = 1'b0;
      case (state_q)
        ST_RUN:  begin state_d = ST_HOUR; blink_clr = 1'b1; end
        ST_HOUR: begin state_d = ST_MIN;  blink_clr = 1'b1; end
        ST_MIN:  begin state_d = ST_RUN;  clr_sec_d = 1'b1; end
        default: begin state_d = ST_RUN; end
      endcase
    end else if (press_q[1] && (state_q != ST_RUN)) begin
      strobe  = 1'b1;
      armed_d = 1'b1;
      first_d = 1'b1;
      rcnt_d  = '0;
    end else if (armed_q) begin
      if (!hold_q) begin
        armed_d = 1'b0;
      end else if (rcnt_q == rep_lim) begin
        strobe  = 1'b1;
        first_d = 1'b0;
        rcnt_d  = '0;
      end else begin
        rcnt_d  = rcnt_q + 1'b1;
      end
    end

    if (strobe) begin
      blink_clr = 1'b1;
    end

    if (blink_clr || (state_d == ST_RUN)) begin
      bcnt_d  = '0;
      phase_d = 1'b0;
    end else if (bcnt_q == BL_MAX) begin
      bcnt_d  = '0;
      phase_d = ~phase_q;
    end else begin
      bcnt_d  = bcnt_q + 1'b1;
    end

    inc_hour_d = strobe && (state_q == ST_HOUR);
    inc_min_d  = strobe && (state_q == ST_MIN);
    run_en_d   = (state_d == ST_RUN);
    case (state_d)
      ST_HOUR: mask_d = {phase_d, phase_d, 4'b0000};
      ST_MIN:  mask_d = {2'b00, phase_d, phase_d, 2'b00};
      default: mask_d = 6'b000000;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      sync1_q    <= 2'b11;
      sync2_q    <= 2'b11;
      db_q       <= 2'b11;
      db_prev_q  <= 2'b11;
      press_q    <= 2'b00;
      dcnt_q     <= '0;
      hold_q     <= 1'b0;
      state_q    <= ST_RUN;
      armed_q    <= 1'b0;
      first_q    <= 1'b0;
      rcnt_q     <= '0;
      bcnt_q     <= '0;
      phase_q    <= 1'b0;
      run_en_q   <= 1'b1;
      inc_hour_q <= 1'b0;
      inc_min_q  <= 1'b0;
      clr_sec_q  <= 1'b0;
      mask_q     <= 6'b000000;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      db_q       <= db_d;
      db_prev_q  <= db_prev_d;
      press_q    <= press_d;
      dcnt_q     <= dcnt_d;
      hold_q     <= hold_d;
      state_q    <= state_d;
      armed_q    <= armed_d;
      first_q    <= first_d;
      rcnt_q     <= rcnt_d;
      bcnt_q     <= bcnt_d;
      phase_q    <= phase_d;
      run_en_q   <= run_en_d;
      inc_hour_q <= inc_hour_d;
      inc_min_q  <= inc_min_d;
      clr_sec_q  <= clr_sec_d;
      mask_q     <= mask_d;
    end
  end

  assign oRunEn     = run_en_q;
  assign oIncHour   = inc_hour_q;
  assign oIncMin    = inc_min_q;
  assign oClrSec    = clr_sec_q;
  assign oMode      = state_q;
  assign oBlankMask = mask_q;

endmodule
